// File: rtl/inc_arbiter_pkg.sv
// Shared definitions for the incrementer arbiter: FSM state encoding and
// the requester-index width helper.
package inc_arbiter_pkg;

  // One operation takes two states: pick/latch, then increment/respond.
  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // Ceiling log2 with a floor of 1 bit, so an index port always exists.
  function automatic int id_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/inc.sv
// Purpose: unsigned DATAWIDTH-bit incrementer, a + 1 with carry-out.
// Latency: combinational.
// Backpressure: none; pure function of the operand.
// Ports: a (operand), y (a+1 modulo 2^DATAWIDTH), co (1 when a was all-ones).
module inc #(
  parameter int DATAWIDTH = 64
) (
  input  logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] y,
  output logic                 co
);

  assign {co, y} = {1'b0, a} + (DATAWIDTH + 1)'(1);

endmodule

// File: rtl/inc_arbiter_rr_pick.sv
// Purpose: round-robin picker, first set req bit scanning up from ptr with wrap.
// Latency: combinational.
// Backpressure: none; any=0 when no request is present.
// Ports: req (request vector), ptr (scan start), winner (picked index), any (some req set).
module inc_arbiter_rr_pick
  import inc_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] cand;

  // Scan offsets from farthest to nearest so the candidate closest to ptr
  // is the last one written and therefore wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (ID_W + 1)'(k);
      if (sum >= (ID_W + 1)'(NUM_REQ)) begin
        sum = sum - (ID_W + 1)'(NUM_REQ);
      end
      cand = sum[ID_W-1:0];
      if (req[cand]) begin
        winner = cand;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inc_arbiter.sv
// Purpose: shares one incrementer among NUM_REQ requesters, round-robin, req/ack.
// Latency: Req sampled at edge N -> Valid/Ack pulse during cycle N+2; one op per 2 cycles.
// Backpressure: requesters hold Req with a stable operand until their one-cycle Ack.
// Ports: Clk, Rst (async, active-low); Req/OpA per requester (OpA packed DATAWIDTH
//        slices); Ack one-hot pulse with Valid; Result/ResId/Carry held until next
//        Valid; Busy high in EXEC.
module inc_arbiter
  import inc_arbiter_pkg::*;
#(
  parameter int DATAWIDTH = 64,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = id_width(NUM_REQ)
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [NUM_REQ-1:0]             Req,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   OpA,
  output logic [NUM_REQ-1:0]             Ack,
  output logic                           Valid,
  output logic [DATAWIDTH-1:0]           Result,
  output logic [ID_W-1:0]                ResId,
  output logic                           Carry,
  output logic                           Busy
);

  state_t                state;
  state_t                state_nxt;
  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       id_q;
  logic [ID_W-1:0]       winner;
  logic                  any;
  logic                  grant;
  logic                  fire;
  logic [DATAWIDTH-1:0]  operand;
  logic [DATAWIDTH-1:0]  inc_sum;
  logic                  inc_co;

  inc_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (Req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  inc #(
    .DATAWIDTH (DATAWIDTH)
  ) u_inc (
    .a  (operand),
    .y  (inc_sum),
    .co (inc_co)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    fire      = 1'b0;
    Busy      = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          grant     = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        Busy      = 1'b1;
        fire      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand and id are captured at grant, so Req/OpA movement during EXEC
  // cannot disturb the operation in flight.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ptr     <= '0;
      id_q    <= '0;
      operand <= '0;
      Result  <= '0;
      ResId   <= '0;
      Carry   <= 1'b0;
      Valid   <= 1'b0;
      Ack     <= '0;
    end else begin
      Valid <= fire;
      Ack   <= fire ? (NUM_REQ'(1) << id_q) : '0;
      if (grant) begin
        operand <= OpA[winner*DATAWIDTH +: DATAWIDTH];
        id_q    <= winner;
      end
      if (fire) begin
        Result <= inc_sum;
        Carry  <= inc_co;
        ResId  <= id_q;
        // Explicit wrap keeps non-power-of-two NUM_REQ inside range.
        ptr    <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/inc_arbiter.md
Name: inc_arbiter

Overview:
- Shares one DATAWIDTH-bit incrementer among NUM_REQ requesters. Each requester presents an operand and receives operand+1.
- Round-robin arbitration, registered result, req/ack handshake.
- Sits between several datapath clients (loop counters, address generators) and a single INC datapath component, so that only one incrementer is built.

Parameters:
DATAWIDTH, 64, operand/result width in bits
NUM_REQ, 4, number of requesters (2..16)
ID_W, clog2(NUM_REQ), width of requester index

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous reset, active-low (0 = reset)
Req  input  NUM_REQ  per-requester request; held high with operand stable until Ack
OpA  input  NUM_REQ*DATAWIDTH  packed operands; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH]
Ack  output  NUM_REQ  one-hot, one-cycle pulse to the served requester, coincident with Valid
Valid  output  1  one-cycle pulse: Result/ResId/Carry valid
Result  output  DATAWIDTH  registered OpA[winner]+1, modulo 2^DATAWIDTH
ResId  output  ID_W  index of the served requester
Carry  output  1  1 when the operand was all-ones (result wrapped to 0)
Busy  output  1  high while in EXEC

Behaviour:
- Reset (Rst=0, async): state=IDLE; Ack=0, Valid=0, Result=0, ResId=0, Carry=0, Busy=0; rr pointer=0; operand register=0.
- States: IDLE, EXEC. Encoding is 1 bit.
- IDLE:
  - If Req!=0, pick the winner as the first set bit scanning from the pointer upward, with wrap to 0.
  - Latch OpA[winner] into the operand register and the winner into the id register. Next state is EXEC.
  - If Req==0, stay in IDLE with no register change.
- EXEC (Busy=1):
  - The shared incrementer computes operand+1.
  - On the clock edge, register Result, Carry (=&operand), ResId=id and Valid=1.
  - Ack[id]=1 for exactly the following cycle.
  - Pointer = (id+1) mod NUM_REQ. Next state is IDLE.
- Latency: Req sampled at edge N → Valid/Ack high during cycle N+2. Throughput is one op per 2 cycles.
- Valid/Ack are pulses: they deassert the cycle after assertion regardless of Req.
- Result/ResId/Carry hold their values until the next Valid.
- A requester must drop Req in the Ack cycle. If Req is still high at the next IDLE sample, it is a new request. Since the pointer has moved, it only wins if no other requester is pending.
- Req changes during EXEC do not affect the current operation: the operand and id are latched.
- A requester that drops Req before Ack is still served. Ack/Valid still pulse and the result is discarded by the client.
- Width: the increment is unsigned modulo 2^DATAWIDTH. All-ones → Result=0, Carry=1.
- Simultaneous requests: exactly one winner per IDLE cycle. No starvation: any continuously asserted Req is served within NUM_REQ operations.
- NUM_REQ not a power of two: pointer wrap uses an explicit compare to NUM_REQ-1, not natural overflow.
- Reset mid-EXEC: the operation is aborted, no Ack/Valid is issued, and the pointer returns to 0.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=1'b0 and EXEC=1'b1;
  - the ID_W clog2 function.
- Natural sub-module rr_pick: combinational round-robin picker.
  - Inputs: Req, pointer.
  - Outputs: winner index and any-valid flag.
- The incrementer is the team's existing INC datapath component, instantiated once with DATAWIDTH passed through.

Test Plan:
- Reset then single request: Req=4'b0010, OpA[1]=64'h0000_0000_0000_0009 → 2 cycles later Valid=1, Ack=4'b0010, ResId=1, Result=64'hA, Carry=0.
- Wrap: Req=4'b0001, OpA[0]=64'hFFFF_FFFF_FFFF_FFFF → Result=0, Carry=1, ResId=0.
- Contention and fairness: all four Req held continuously from reset → ResId sequence 0,1,2,3,0, with a Valid every 2nd cycle; each Ack is one cycle wide.
- Pointer skip: after serving id 2, Req=4'b0011 → next served is 0, then 1 (id 3 has no request, so the pointer scan wraps).
- Operand stability: change OpA[3] from 5 to 99 during the EXEC cycle after a grant to 3 → Result=6.
- Async reset mid-op: assert Rst=0 during EXEC → Ack, Valid, Busy and Result go to 0 immediately, with no Valid pulse. After release, Req=4'b1000 → ResId=3 is served normally with the pointer restarted from 0.
